// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
//   Loads the instruction memory from a framed UART byte stream.
//   Frame format: SYNC_BYTE, N (word count), then 4*N data bytes, LSB first.
//   Each completed word is issued to the IMEM write port as a one-cycle pulse.
//   While a frame is being loaded, or after an error, the core is held and
//   the IMEM address is taken from the loader instead of the core PC.
//
//   Build option: define LOADER_CHECKSUM_EN to add a trailing checksum byte
//   (XOR of all data bytes, 8'h00 when N==0). A mismatch leaves the loader
//   in ERROR with the core still held.
//
// Ports
//   CLK            in   1   clock, all logic on posedge
//   reset          in   1   synchronous, active-high
//   rx_data        in   8   received UART byte
//   rx_valid       in   1   one-cycle strobe qualifying rx_data
//   pc             in   32  core PC (byte address)
//   imem_we        out  1   IMEM write enable
//   imem_a         out  32  IMEM address (loader address while held, else pc)
//   imem_wd        out  32  IMEM write data
//   core_hold      out  1   core is stalled / held in reset
//   busy           out  1   a frame is in progress
//   done           out  1   one-cycle pulse at successful frame end
//   err            out  1   sticky error flag, cleared by a new SYNC_BYTE
//   words_written  out  8   words written in the current/last frame
// -----------------------------------------------------------------------------
module imem_uart_loader #(
  parameter int         DEPTH       = 20,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] pc,
  output logic        imem_we,
  output logic [31:0] imem_a,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  words_written
);

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    DEPTH_B = 8'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_ERROR} state_t;
`endif

  state_t        state_reg;
  logic [7:0]    n_words_reg;
  logic [7:0]    word_idx_reg;      // words issued so far in this frame
  logic [1:0]    byte_cnt_reg;      // byte position inside the current word
  logic [TW-1:0] to_cnt_reg;        // idle cycles since the last accepted byte
  logic [31:0]   loader_addr_reg;
  logic [23:0]   asm_reg;           // lower three bytes of the word being built
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    chk_acc_reg;
`endif

  // A data byte is taken only while words are still outstanding; once the
  // last word has been issued the DATA state just closes the frame.
  logic       data_accept;
  logic [2:0] lane_hit;

  assign data_accept = (state_reg == S_DATA) && rx_valid &&
                       (word_idx_reg != n_words_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_hit[gi] = data_accept && (byte_cnt_reg == 2'(gi));
    end
  endgenerate

  assign imem_a = core_hold ? loader_addr_reg : pc;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      n_words_reg     <= '0;
      word_idx_reg    <= '0;
      byte_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
      loader_addr_reg <= '0;
      asm_reg         <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc_reg     <= '0;
`endif
      imem_we         <= 1'b0;
      imem_wd         <= '0;
      core_hold       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      words_written   <= '0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;

      for (int i = 0; i < 3; i++) begin
        if (lane_hit[i]) asm_reg[i*8 +: 8] <= rx_data;
      end

      case (state_reg)
        S_IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_reg    <= S_LEN;
            core_hold    <= 1'b1;
            busy         <= 1'b1;
            to_cnt_reg   <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_reg  <= '0;
`endif
          end
        end

        S_LEN: begin
          if (rx_valid) begin
            to_cnt_reg    <= '0;
            words_written <= '0;
            if (rx_data == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_reg <= S_CHK;
`else
              state_reg <= S_IDLE;
              core_hold <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
`endif
            end else if (rx_data > DEPTH_B) begin
              state_reg <= S_ERROR;
              err       <= 1'b1;
              busy      <= 1'b0;
            end else begin
              n_words_reg <= rx_data;
              state_reg   <= S_DATA;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            state_reg <= S_ERROR;
            err       <= 1'b1;
            busy      <= 1'b0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        S_DATA: begin
          if (word_idx_reg == n_words_reg) begin
            // The final write pulse is high during this cycle; releasing the
            // core one edge later keeps imem_we inside the hold window.
            state_reg <= S_IDLE;
            core_hold <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (rx_valid) begin
            to_cnt_reg   <= '0;
            byte_cnt_reg <= byte_cnt_reg + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_reg  <= chk_acc_reg ^ rx_data;
`endif
            if (byte_cnt_reg == 2'd3) begin
              imem_we         <= 1'b1;
              imem_wd         <= {rx_data, asm_reg};
              loader_addr_reg <= {22'd0, word_idx_reg, 2'b00};
              words_written   <= words_written + 1'b1;
              word_idx_reg    <= word_idx_reg + 1'b1;
`ifdef LOADER_CHECKSUM_EN
              if (word_idx_reg + 8'd1 == n_words_reg) state_reg <= S_CHK;
`endif
            end
          end else if (to_cnt_reg == TO_LAST) begin
            state_reg <= S_ERROR;
            err       <= 1'b1;
            busy      <= 1'b0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            to_cnt_reg <= '0;
            if (rx_data == chk_acc_reg) begin
              state_reg <= S_IDLE;
              core_hold <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= S_ERROR;
              err       <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (to_cnt_reg == TO_LAST) begin
            state_reg <= S_ERROR;
            err       <= 1'b1;
            busy      <= 1'b0;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
`endif

        S_ERROR: begin
          // Core stays held; only a fresh frame start leaves this state.
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_reg    <= S_LEN;
            err          <= 1'b0;
            busy         <= 1'b1;
            to_cnt_reg   <= '0;
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_acc_reg  <= '0;
`endif
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_uart_loader
//   Directed bench for imem_uart_loader. A negedge monitor logs every IMEM
//   write and done pulse; each scenario task compares against hand-computed
//   values. The timeout is shortened so the timeout scenario stays small.
// -----------------------------------------------------------------------------
module tb_imem_uart_loader;

  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] pc;
  logic        imem_we;
  logic [31:0] imem_a;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  words_written;

  imem_uart_loader #(
    .DEPTH(20),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .pc(pc),
    .imem_we(imem_we),
    .imem_a(imem_a),
    .imem_wd(imem_wd),
    .core_hold(core_hold),
    .busy(busy),
    .done(done),
    .err(err),
    .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  int          we_cnt   = 0;
  int          done_cnt = 0;
  int          viol_cnt = 0;
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];

  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      if (we_cnt < 64) begin
        wr_a[we_cnt] = imem_a;
        wr_d[we_cnt] = imem_wd;
      end
      we_cnt = we_cnt + 1;
      if (core_hold !== 1'b1) viol_cnt = viol_cnt + 1;
    end
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    $display("tx byte %02h", b);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      rx_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pc       = 32'h8;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    n_cmp++; if (imem_a !== 32'h8) begin n_bad++; $display("FAIL reset_imem_a got %08h want %08h", imem_a, 32'h8); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we got %b want 0", imem_we); end
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL reset_core_hold got %b want 0", core_hold); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if ({busy, done, words_written, imem_wd} !== 42'd0) begin n_bad++; $display("FAIL reset_misc got busy=%b done=%b ww=%0d wd=%08h want all 0", busy, done, words_written, imem_wd); end
    $display("reset: imem_a=%08h core_hold=%b err=%b", imem_a, core_hold, err);
  endtask

  task automatic test_single_word;
    int b_we, b_done;
    b_we = we_cnt; b_done = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    n_cmp++; if ({busy, core_hold} !== 2'b11) begin n_bad++; $display("FAIL single_busy_hold got %b%b want 11", busy, core_hold); end
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h50);
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h43);
`endif
    idle_cycles(6);
    n_cmp++; if (we_cnt - b_we !== 1) begin n_bad++; $display("FAIL single_we_count got %0d want 1", we_cnt - b_we); end
    n_cmp++; if (wr_a[b_we] !== 32'h0) begin n_bad++; $display("FAIL single_addr got %08h want 00000000", wr_a[b_we]); end
    n_cmp++; if (wr_d[b_we] !== 32'h00500013) begin n_bad++; $display("FAIL single_data got %08h want 00500013", wr_d[b_we]); end
    n_cmp++; if (done_cnt - b_done !== 1) begin n_bad++; $display("FAIL single_done got %0d want 1", done_cnt - b_done); end
    n_cmp++; if ({core_hold, busy, err} !== 3'b000) begin n_bad++; $display("FAIL single_flags got hold=%b busy=%b err=%b want 000", core_hold, busy, err); end
    n_cmp++; if (words_written !== 8'd1) begin n_bad++; $display("FAIL single_words got %0d want 1", words_written); end
    n_cmp++; if (imem_a !== 32'h8) begin n_bad++; $display("FAIL single_pc_mux got %08h want 00000008", imem_a); end
    $display("single word: we=%0d wd=%08h done=%0d", we_cnt - b_we, wr_d[b_we], done_cnt - b_done);
  endtask

  task automatic test_back_to_back;
    int b_we, b_done;
    logic [7:0] seq [10];
    seq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h66, 8'h77, 8'h88};
    b_we = we_cnt; b_done = done_cnt;
    pc = 32'h40;
    for (int i = 0; i < 10; i++) send_byte(seq[i]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h78);
`endif
    idle_cycles(6);
    n_cmp++; if (we_cnt - b_we !== 2) begin n_bad++; $display("FAIL b2b_we_count got %0d want 2", we_cnt - b_we); end
    n_cmp++; if ({wr_a[b_we], wr_d[b_we]} !== {32'h0, 32'h44332211}) begin n_bad++; $display("FAIL b2b_word0 got a=%08h d=%08h want a=00000000 d=44332211", wr_a[b_we], wr_d[b_we]); end
    n_cmp++; if ({wr_a[b_we+1], wr_d[b_we+1]} !== {32'h4, 32'h887766A5}) begin n_bad++; $display("FAIL b2b_word1 got a=%08h d=%08h want a=00000004 d=887766a5", wr_a[b_we+1], wr_d[b_we+1]); end
    n_cmp++; if (words_written !== 8'd2) begin n_bad++; $display("FAIL b2b_words got %0d want 2", words_written); end
    n_cmp++; if ({done_cnt - b_done, err} !== {32'd1, 1'b0}) begin n_bad++; $display("FAIL b2b_done got done=%0d err=%b want done=1 err=0", done_cnt - b_done, err); end
    $display("back-to-back: we=%0d w0=%08h w1=%08h", we_cnt - b_we, wr_d[b_we], wr_d[b_we+1]);
  endtask

  task automatic test_full_depth;
    int b_we, b_done;
    b_we = we_cnt; b_done = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h14);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i));
      send_byte(8'h5A);
      send_byte(8'(i));
      send_byte(8'hC0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle_cycles(6);
    n_cmp++; if (we_cnt - b_we !== 20) begin n_bad++; $display("FAIL depth_we_count got %0d want 20", we_cnt - b_we); end
    n_cmp++; if ({wr_a[b_we+19], wr_d[b_we+19]} !== {32'd76, 32'hC0135A13}) begin n_bad++; $display("FAIL depth_last got a=%08h d=%08h want a=0000004c d=c0135a13", wr_a[b_we+19], wr_d[b_we+19]); end
    n_cmp++; if (words_written !== 8'd20) begin n_bad++; $display("FAIL depth_words got %0d want 20", words_written); end
    n_cmp++; if ({done_cnt - b_done, core_hold, err} !== {32'd1, 2'b00}) begin n_bad++; $display("FAIL depth_end got done=%0d hold=%b err=%b want 1 0 0", done_cnt - b_done, core_hold, err); end
    $display("full depth: we=%0d last=%08h", we_cnt - b_we, wr_d[b_we+19]);
  endtask

  task automatic test_len_error;
    int b_we, b_done;
    b_we = we_cnt; b_done = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h15);
    idle_cycles(3);
    n_cmp++; if ({err, core_hold, busy} !== 3'b110) begin n_bad++; $display("FAIL lenerr_flags got err=%b hold=%b busy=%b want 1 1 0", err, core_hold, busy); end
    n_cmp++; if (we_cnt - b_we !== 0) begin n_bad++; $display("FAIL lenerr_no_write got %0d want 0", we_cnt - b_we); end
    n_cmp++; if (done_cnt - b_done !== 0) begin n_bad++; $display("FAIL lenerr_no_done got %0d want 0", done_cnt - b_done); end
    send_byte(8'hA5);
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle_cycles(4);
    n_cmp++; if ({err, core_hold} !== 2'b00) begin n_bad++; $display("FAIL lenerr_recover got err=%b hold=%b want 0 0", err, core_hold); end
    n_cmp++; if (done_cnt - b_done !== 1) begin n_bad++; $display("FAIL lenerr_done got %0d want 1", done_cnt - b_done); end
    $display("len error: err=%b hold=%b done=%0d", err, core_hold, done_cnt - b_done);
  endtask

  task automatic test_timeout;
    int b_we;
    b_we = we_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    idle_cycles(1);
    idle_cycles(TO - 1);
    n_cmp++; if ({err, busy} !== 2'b01) begin n_bad++; $display("FAIL timeout_early got err=%b busy=%b want 0 1", err, busy); end
    idle_cycles(1);
    n_cmp++; if ({err, core_hold, busy} !== 3'b110) begin n_bad++; $display("FAIL timeout_flags got err=%b hold=%b busy=%b want 1 1 0", err, core_hold, busy); end
    n_cmp++; if (we_cnt - b_we !== 0) begin n_bad++; $display("FAIL timeout_no_write got %0d want 0", we_cnt - b_we); end
    $display("timeout: err=%b hold=%b", err, core_hold);

    // New frame, reset arrives on the same edge as the fourth data byte.
    b_we = we_cnt;
    pc = 32'h1234;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge CLK);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    reset    = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    n_cmp++; if ({imem_we, core_hold, busy, done, err} !== 5'b0) begin n_bad++; $display("FAIL midreset_flags got we=%b hold=%b busy=%b done=%b err=%b want 00000", imem_we, core_hold, busy, done, err); end
    n_cmp++; if ({words_written, imem_wd} !== 40'd0) begin n_bad++; $display("FAIL midreset_regs got ww=%0d wd=%08h want 0 0", words_written, imem_wd); end
    n_cmp++; if (imem_a !== 32'h1234) begin n_bad++; $display("FAIL midreset_imem_a got %08h want 00001234", imem_a); end
    reset = 1'b0;
    idle_cycles(3);
    n_cmp++; if (we_cnt - b_we !== 0) begin n_bad++; $display("FAIL midreset_no_write got %0d want 0", we_cnt - b_we); end
    $display("mid-frame reset: hold=%b err=%b ww=%0d", core_hold, err, words_written);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int b_we, b_done;
    b_we = we_cnt; b_done = done_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'hFF);
    idle_cycles(4);
    n_cmp++; if (we_cnt - b_we !== 1) begin n_bad++; $display("FAIL chk_we_count got %0d want 1", we_cnt - b_we); end
    n_cmp++; if (wr_d[b_we] !== 32'h04030201) begin n_bad++; $display("FAIL chk_data got %08h want 04030201", wr_d[b_we]); end
    n_cmp++; if ({err, core_hold, done_cnt - b_done} !== {2'b11, 32'd0}) begin n_bad++; $display("FAIL chk_err got err=%b hold=%b done=%0d want 1 1 0", err, core_hold, done_cnt - b_done); end
    $display("checksum mismatch: err=%b hold=%b", err, core_hold);
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_depth();
    test_len_error();
    test_timeout();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    n_cmp++; if (viol_cnt !== 0) begin n_bad++; $display("FAIL we_outside_hold got %0d want 0", viol_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
